button_debouncer: RTL and testbench

//   Input-side companion to the LED driver: conditions the raw board push-buttons into clean,

---
 rtl/button_debouncer.sv | 104 ++++++++++
 tb/tb_button_debouncer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer
//   Conditions raw push-button pins into clean debounced levels and event strobes.
//   Per channel: 2-flop synchronizer with polarity normalisation, a stability-counter
//   debounce, registered press/release strobes and a one-shot long-press strobe.
// Ports
//   i_clk     : system clock
//   i_rst     : asynchronous, active-high reset
//   i_btn     : raw asynchronous button pins
//   o_state   : debounced level, 1 = pressed
//   o_press   : 1-cycle strobe on a debounced 0->1 change
//   o_release : 1-cycle strobe on a debounced 1->0 change
//   o_long    : 1-cycle strobe once a press has lasted HOLD_CYCLES
module button_debouncer #(
  parameter int unsigned     NBTN            = 7,
  parameter logic [NBTN-1:0] ACTIVE_LOW_MASK = 7'b0000001,
  parameter int unsigned     DEBOUNCE_CYCLES = 250000,
  parameter int unsigned     HOLD_CYCLES     = 25000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NBTN-1:0] i_btn,
  output logic [NBTN-1:0] o_state,
  output logic [NBTN-1:0] o_press,
  output logic [NBTN-1:0] o_release,
  output logic [NBTN-1:0] o_long
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES);

  logic [NBTN-1:0]         sync1_q, sync1_d;
  logic [NBTN-1:0]         sync2_q, sync2_d;
  logic [NBTN-1:0]         state_q, state_d;
  logic [NBTN-1:0]         press_q, press_d;
  logic [NBTN-1:0]         release_q, release_d;
  logic [NBTN-1:0]         long_q, long_d;
  logic [NBTN-1:0][DW-1:0] dcnt_q, dcnt_d;
  logic [NBTN-1:0][HW-1:0] hcnt_q, hcnt_d;

  // Register bank; reset leaves every channel in the released state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
    end
  end

  // Next-state logic for synchronizer, debounce and hold counters.
  always_comb begin
    sync1_d   = i_btn ^ ACTIVE_LOW_MASK;
    sync2_d   = sync1_q;
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;

    for (int i = 0; i < int'(NBTN); i++) begin
      // Any cycle of agreement restarts the stability window.
      if (sync2_q[i] == state_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DMAX) begin
        state_d[i]   = sync2_q[i];
        dcnt_d[i]    = '0;
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end

      // Hold counter saturates at HMAX so the long strobe fires once per press.
      if (!state_q[i]) begin
        hcnt_d[i] = '0;
      end else if (hcnt_q[i] != HMAX) begin
        hcnt_d[i] = hcnt_q[i] + HW'(1);
        long_d[i] = (hcnt_d[i] == HMAX);
      end
    end
  end

  assign o_state   = state_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer
//   Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
//   Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_button_debouncer;

  localparam int unsigned NBTN = 7;

  logic            clk;
  logic            rst;
  logic [NBTN-1:0] btn;
  logic [NBTN-1:0] st;
  logic [NBTN-1:0] pr;
  logic [NBTN-1:0] rl;
  logic [NBTN-1:0] lg;

  int total;
  int bad;

  button_debouncer #(
    .NBTN           (7),
    .ACTIVE_LOW_MASK(7'b0000001),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn    (btn),
    .o_state  (st),
    .o_press  (pr),
    .o_release(rl),
    .o_long   (lg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 7'b0000001;
    tick();
    tick();
    total++;
    if ({st, pr, rl, lg} !== 28'h0) begin
      bad++;
      $display("FAIL reset_hold got st=%b pr=%b rl=%b lg=%b want all 0", st, pr, rl, lg);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if ({st, pr, rl, lg} !== 28'h0) begin
        bad++;
        $display("FAIL reset_idle k=%0d got st=%b pr=%b rl=%b lg=%b want all 0", k, st, pr, rl, lg);
      end
    end
  endtask

  task automatic test_clean_press();
    btn[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (pr !== ((k == 6) ? 7'b0000010 : 7'b0) || st !== ((k >= 6) ? 7'b0000010 : 7'b0)
          || rl !== 7'b0 || lg !== 7'b0) begin
        bad++;
        $display("FAIL clean_press k=%0d got st=%b pr=%b rl=%b lg=%b", k, st, pr, rl, lg);
      end
    end
    btn[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (rl !== ((k == 6) ? 7'b0000010 : 7'b0) || st !== ((k >= 6) ? 7'b0 : 7'b0000010)
          || pr !== 7'b0 || lg !== 7'b0) begin
        bad++;
        $display("FAIL clean_release k=%0d got st=%b pr=%b rl=%b lg=%b", k, st, pr, rl, lg);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    pat = 8'b00110011;  // applied LSB first: 1,1,0,0,1,1,0,0
    for (int k = 0; k < 8; k++) begin
      btn[1] = pat[k];
      tick();
      total++;
      if (pr !== 7'b0 || st !== 7'b0 || rl !== 7'b0) begin
        bad++;
        $display("FAIL bounce_quiet k=%0d got st=%b pr=%b rl=%b want 0", k, st, pr, rl);
      end
    end
    btn[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (pr !== ((k == 6) ? 7'b0000010 : 7'b0) || st !== ((k >= 6) ? 7'b0000010 : 7'b0)) begin
        bad++;
        $display("FAIL bounce_press k=%0d got st=%b pr=%b", k, st, pr);
      end
    end
    btn[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (rl !== ((k == 6) ? 7'b0000010 : 7'b0) || lg !== 7'b0) begin
        bad++;
        $display("FAIL bounce_release k=%0d got rl=%b lg=%b", k, rl, lg);
      end
    end
  endtask

  task automatic test_glitch();
    btn[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) btn[2] = 1'b0;
      total++;
      if (st !== 7'b0 || pr !== 7'b0 || rl !== 7'b0) begin
        bad++;
        $display("FAIL glitch k=%0d got st=%b pr=%b rl=%b want 0", k, st, pr, rl);
      end
    end
  endtask

  task automatic test_long_press();
    for (int rep = 0; rep < 2; rep++) begin
      btn[3] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
        tick();
        total++;
        if (pr !== ((k == 6) ? 7'b0001000 : 7'b0) || lg !== 7'b0) begin
          bad++;
          $display("FAIL long_press rep=%0d k=%0d got pr=%b lg=%b", rep, k, pr, lg);
        end
      end
      for (int m = 1; m <= 10; m++) begin
        tick();
        total++;
        if (lg !== ((m == 10) ? 7'b0001000 : 7'b0) || st !== 7'b0001000) begin
          bad++;
          $display("FAIL long_fire rep=%0d m=%0d got lg=%b st=%b", rep, m, lg, st);
        end
      end
      for (int m = 1; m <= 50; m++) begin
        tick();
        total++;
        if (lg !== 7'b0 || st !== 7'b0001000 || pr !== 7'b0) begin
          bad++;
          $display("FAIL long_once rep=%0d m=%0d got lg=%b st=%b pr=%b", rep, m, lg, st, pr);
        end
      end
      btn[3] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        tick();
        total++;
        if (rl !== ((k == 6) ? 7'b0001000 : 7'b0) || lg !== 7'b0) begin
          bad++;
          $display("FAIL long_release rep=%0d k=%0d got rl=%b lg=%b", rep, k, rl, lg);
        end
      end
    end
  endtask

  task automatic test_active_low();
    btn[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (pr !== ((k == 6) ? 7'b0000001 : 7'b0) || st !== ((k >= 6) ? 7'b0000001 : 7'b0)) begin
        bad++;
        $display("FAIL active_low_press k=%0d got st=%b pr=%b", k, st, pr);
      end
    end
    btn[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (rl !== ((k == 6) ? 7'b0000001 : 7'b0) || st !== ((k >= 6) ? 7'b0 : 7'b0000001)) begin
        bad++;
        $display("FAIL active_low_release k=%0d got st=%b rl=%b", k, st, rl);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Get channel 1 pressed so the reset has a visible effect.
    btn[1] = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    total++;
    if (st !== 7'b0000010) begin
      bad++;
      $display("FAIL reset_mid_pre got st=%b want 0000010", st);
    end
    btn[4] = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b1;
    #1;
    total++;
    if ({st, pr, rl, lg} !== 28'h0) begin
      bad++;
      $display("FAIL reset_mid_async got st=%b pr=%b rl=%b lg=%b want all 0", st, pr, rl, lg);
    end
    btn[1] = 1'b0;
    tick();
    tick();
    total++;
    if ({st, pr, rl, lg} !== 28'h0) begin
      bad++;
      $display("FAIL reset_mid_hold got st=%b pr=%b rl=%b lg=%b want all 0", st, pr, rl, lg);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (pr !== ((k == 6) ? 7'b0010000 : 7'b0) || st !== ((k >= 6) ? 7'b0010000 : 7'b0)
          || rl !== 7'b0) begin
        bad++;
        $display("FAIL reset_mid_press k=%0d got st=%b pr=%b rl=%b", k, st, pr, rl);
      end
    end
  endtask

  task automatic test_back_to_back();
    btn[5] = 1'b1;
    btn[6] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (pr !== ((k == 6) ? 7'b1100000 : 7'b0)
          || (st & 7'b1100000) !== ((k >= 6) ? 7'b1100000 : 7'b0)) begin
        bad++;
        $display("FAIL simultaneous k=%0d got st=%b pr=%b", k, st, pr);
      end
    end
    btn = 7'b0000001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (rl !== ((k == 6) ? 7'b1110000 : 7'b0) || pr !== 7'b0) begin
        bad++;
        $display("FAIL simultaneous_release k=%0d got rl=%b pr=%b", k, rl, pr);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    btn   = 7'b0000001;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_press();
    test_active_low();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
